alu_ctrl_decode_reg: RTL

//  ID->EX producer for the ALU control interface. Decodes the RV32I instruction in Decode

---
 rtl/alu_ctrl_decode_reg.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_decode_reg.sv
// ID->EX stage register for the ALU control path.
// Decodes the RV32I instruction held in Decode into the EX-stage ALU encoding.
// Selects operand b, then registers everything into EX with stall/flush control.
// Illegal encodings still flow down as valid instructions, flagged by illegal_e.

module alu_ctrl_decode_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_e,
   input  logic             flush_e,
   input  logic             valid_d,
   input  logic [31:0]      instr_d,
   input  logic [WIDTH-1:0] rd1_d,
   input  logic [WIDTH-1:0] rd2_d,
   input  logic [WIDTH-1:0] imm_ext_d,
   output logic             valid_e,
   output logic [3:0]       alu_ctrl_e,
   output logic             funct7b5_e,
   output logic [WIDTH-1:0] src_a_e,
   output logic [WIDTH-1:0] src_b_e,
   output logic             alu_src_b_e,
   output logic             illegal_e
);

   // ALU operation encoding consumed by the EX-stage ALU
   localparam logic [3:0] AluAdd  = 4'b0000;
   localparam logic [3:0] AluSub  = 4'b0001;
   localparam logic [3:0] AluAnd  = 4'b0010;
   localparam logic [3:0] AluOr   = 4'b0011;
   localparam logic [3:0] AluXor  = 4'b0100;
   localparam logic [3:0] AluSr   = 4'b0101;
   localparam logic [3:0] AluSltu = 4'b0110;
   localparam logic [3:0] AluSll  = 4'b0111;
   localparam logic [3:0] AluSlt  = 4'b1000;

   // RV32I major opcodes
   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   localparam logic [6:0] F7Zero = 7'b0000000;
   localparam logic [6:0] F7Alt  = 7'b0100000;

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;

   assign op = instr_d[6:0];
   assign f3 = instr_d[14:12];
   assign f7 = instr_d[31:25];

   // Decoded fields for the instruction currently in Decode
   logic [3:0]       alu_ctrl_d;
   logic             funct7b5_d;
   logic             alu_src_b_d;
   logic             illegal_d;
   logic [WIDTH-1:0] src_b_d;

   // Shared funct3 -> ALU op map for register and immediate ALU instructions
   function automatic logic [3:0] f3_to_alu(input logic [2:0] fn3);
      logic [3:0] res;
      res = AluAdd;
      unique case (fn3)
         3'b000: res = AluAdd;
         3'b001: res = AluSll;
         3'b010: res = AluSlt;
         3'b011: res = AluSltu;
         3'b100: res = AluXor;
         3'b101: res = AluSr;
         3'b110: res = AluOr;
         3'b111: res = AluAnd;
         default: res = AluAdd;
      endcase
      return res;
   endfunction

   // Instruction decode: ALU op, operand-b select and legality
   always_comb begin
      alu_ctrl_d  = AluAdd;
      alu_src_b_d = 1'b0;
      illegal_d   = 1'b0;

      unique case (op)
         OpR: begin
            alu_src_b_d = 1'b0;
            if (f3 == 3'b000 && f7 == F7Alt) begin
               alu_ctrl_d = AluSub;
            end else begin
               alu_ctrl_d = f3_to_alu(f3);
            end
            // Alternate funct7 only exists for SUB and SRA
            if (!(f7 == F7Zero || (f7 == F7Alt && (f3 == 3'b000 || f3 == 3'b101)))) begin
               illegal_d = 1'b1;
            end
         end
         OpImm: begin
            alu_src_b_d = 1'b1;
            alu_ctrl_d  = f3_to_alu(f3);
            // Upper immediate bits are shamt qualifiers only for the shifts
            if (f3 == 3'b001 && f7 != F7Zero) begin
               illegal_d = 1'b1;
            end
            if (f3 == 3'b101 && !(f7 == F7Zero || f7 == F7Alt)) begin
               illegal_d = 1'b1;
            end
         end
         OpLoad, OpStore, OpLui, OpAuipc, OpJal, OpJalr: begin
            alu_ctrl_d  = AluAdd;
            alu_src_b_d = 1'b1;
         end
         OpBranch: begin
            alu_src_b_d = 1'b0;
            unique case (f3)
               3'b000, 3'b001: alu_ctrl_d = AluSub;
               3'b100, 3'b101: alu_ctrl_d = AluSlt;
               3'b110, 3'b111: alu_ctrl_d = AluSltu;
               default:        illegal_d  = 1'b1;
            endcase
         end
         default: begin
            illegal_d = 1'b1;
         end
      endcase

      if (illegal_d) begin
         alu_ctrl_d  = AluAdd;
         alu_src_b_d = 1'b0;
      end
   end

   // Shift type only matters to the ALU for right shifts
   always_comb begin
      funct7b5_d = (alu_ctrl_d == AluSr) ? instr_d[30] : 1'b0;
      src_b_d    = alu_src_b_d ? imm_ext_d : rd2_d;
   end

   // EX register: reset > flush > stall > load; an invalid Decode loads a bubble
   always_ff @(posedge clk) begin
      if (reset || flush_e) begin
         valid_e     <= 1'b0;
         alu_ctrl_e  <= 4'b0000;
         funct7b5_e  <= 1'b0;
         src_a_e     <= '0;
         src_b_e     <= '0;
         alu_src_b_e <= 1'b0;
         illegal_e   <= 1'b0;
      end else if (stall_e) begin
         valid_e     <= valid_e;
         alu_ctrl_e  <= alu_ctrl_e;
         funct7b5_e  <= funct7b5_e;
         src_a_e     <= src_a_e;
         src_b_e     <= src_b_e;
         alu_src_b_e <= alu_src_b_e;
         illegal_e   <= illegal_e;
      end else if (!valid_d) begin
         valid_e     <= 1'b0;
         alu_ctrl_e  <= 4'b0000;
         funct7b5_e  <= 1'b0;
         src_a_e     <= '0;
         src_b_e     <= '0;
         alu_src_b_e <= 1'b0;
         illegal_e   <= 1'b0;
      end else begin
         valid_e     <= 1'b1;
         alu_ctrl_e  <= alu_ctrl_d;
         funct7b5_e  <= funct7b5_d;
         src_a_e     <= rd1_d;
         src_b_e     <= src_b_d;
         alu_src_b_e <= alu_src_b_d;
         illegal_e   <= illegal_d;
      end
   end

endmodule
